// File: rtl/rssi_pkg.sv
// Shared constants and types for the RSSI power-average / dB path.
//   LOG2_LUT : fractional log2 table, LOG2_LUT[m] = round(256*log2(1+m/16))
//   DB_SCALE : round(256*10*log10(2)); together with DB_SHIFT maps Q6.8 log2 to Q8.4 dB
//   conv_state_t : states of the dB conversion sequencer
package rssi_pkg;

    localparam logic [7:0] LOG2_LUT [16] = '{
        8'd0,   8'd22,  8'd44,  8'd63,  8'd82,  8'd100, 8'd118, 8'd134,
        8'd150, 8'd165, 8'd179, 8'd193, 8'd207, 8'd220, 8'd232, 8'd244
    };

    localparam int DB_SCALE = 771;
    localparam int DB_SHIFT = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOD,
        ST_LUT,
        ST_SCALE,
        ST_OUT
    } conv_state_t;

endpackage

// File: rtl/log2_q8.sv
// Approximate log2 of an unsigned value in Q6.8 (integer part = leading-one index,
// fraction = table lookup on the 4 bits below the leading one).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   ld         : capture leading-one index and mantissa bits of avg
//   avg        : unsigned operand
//   log2_q     : {e, LOG2_LUT[m]} from the captured fields
module log2_q8
    import rssi_pkg::*;
#(
    parameter int AVG_W = 36,
    parameter int E_W   = $clog2(AVG_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [AVG_W-1:0] avg,
    output logic [E_W+7:0]   log2_q
);

    logic [E_W-1:0]   lead;
    logic [3:0]       frac;
    logic [AVG_W+2:0] ext;
    logic [E_W-1:0]   e_p1;
    logic [3:0]       m_p1;

    // Highest set bit wins; avg == 0 yields e = 0, same as avg == 1.
    always_comb begin
        lead = '0;
        for (int i = 0; i < AVG_W; i++) begin
            if (avg[i]) lead = E_W'(i);
        end
    end

    // Four zeros appended so the 4 bits below a small leading one come out zero-padded.
    // The MSB of avg can only ever be the leading one, never a mantissa bit.
    always_comb begin
        ext  = {avg[AVG_W-2:0], 4'b0000};
        frac = ext[lead +: 4];
    end

    // ---- stage p1: captured leading-one fields ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_p1 <= '0;
            m_p1 <= '0;
        end else if (ld) begin
            e_p1 <= lead;
            m_p1 <= frac;
        end
    end

    // The table never reaches 256, so e*256 + LUT[m] is a plain concatenation.
    assign log2_q = {e_p1, LOG2_LUT[m_p1]};

endmodule

// File: rtl/rssi_pow_avg_db.sv
// Block-averages power samples over 2^LOG2_WIN accepted samples, converts the mean to
// dB (Q8.4, relative to 1 LSB^2) and presents it with a single-cycle valid pulse.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : 1 = averaging enabled, 0 = clear window in progress
//   pow_vld    : pow carries a sample this cycle
//   pow        : signed power sample, negative values treated as 0
//   rssi_vld   : one-cycle pulse when rssi_db / avg_pow update
//   rssi_db    : mean power in dB, unsigned Q8.4
//   avg_pow    : mean linear power (window sum >> LOG2_WIN)
module rssi_pow_avg_db
    import rssi_pkg::*;
#(
    parameter int POW_WIDTH = 37,
    parameter int LOG2_WIN  = 6,
    parameter int DB_WIDTH  = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        pow_vld,
    input  logic signed [POW_WIDTH-1:0] pow,
    output logic                        rssi_vld,
    output logic [DB_WIDTH-1:0]         rssi_db,
    output logic [POW_WIDTH-2:0]        avg_pow
);

    localparam int AVG_W  = POW_WIDTH - 1;
    localparam int ACC_W  = AVG_W + LOG2_WIN;
    localparam int E_W    = $clog2(AVG_W);
    localparam int LQ_W   = E_W + 8;
    localparam int PROD_W = LQ_W + 10;

    function automatic logic [AVG_W-1:0] clamp_pow(input logic signed [POW_WIDTH-1:0] p);
        return p[POW_WIDTH-1] ? '0 : p[AVG_W-1:0];
    endfunction

    // Q6.8 log2 * 771 >> 12 gives Q8.4 dB; truncation toward zero.
    function automatic logic [DB_WIDTH-1:0] scale_db(input logic [LQ_W-1:0] lq);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(lq) * PROD_W'(DB_SCALE);
        return DB_WIDTH'(prod >> DB_SHIFT);
    endfunction

    logic [AVG_W-1:0]    samp_p0;
    logic                accept_p0;
    logic                last_p0;
    logic                win_done;
    logic [ACC_W-1:0]    sum_p0;
    logic [ACC_W-1:0]    acc;
    logic [LOG2_WIN-1:0] cnt;
    logic [AVG_W-1:0]    avg_lat;

    conv_state_t         state;
    conv_state_t         state_nxt;
    logic                ld_lod;
    logic                ld_lut;
    logic                ld_scale;
    logic                ld_out;

    logic [LQ_W-1:0]     log2_q_p1;
    logic [LQ_W-1:0]     log2_q_p2;
    logic [DB_WIDTH-1:0] db_p3;

    // ---- stage p0: sample accept and accumulation ----
    assign samp_p0   = clamp_pow(pow);
    assign accept_p0 = en & pow_vld;
    assign last_p0   = (cnt == '1);
    assign win_done  = accept_p0 & last_p0;
    assign sum_p0    = acc + ACC_W'(samp_p0);

    // Accumulator is wide enough for 2^LOG2_WIN full-scale samples, so no saturation.
    // The closing sample is folded into the latched mean and the next window starts
    // from zero on the following cycle, so no sample is lost between windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            avg_lat <= '0;
        end else if (!en) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept_p0) begin
            if (last_p0) begin
                acc     <= '0;
                cnt     <= '0;
                avg_lat <= AVG_W'(sum_p0 >> LOG2_WIN);
            end else begin
                acc <= sum_p0;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Conversion sequencer: a window is always longer than the 5-cycle sequence, so a
    // new window can never end while a conversion is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (win_done) state_nxt = ST_LOD;
            ST_LOD:   state_nxt = ST_LUT;
            ST_LUT:   state_nxt = ST_SCALE;
            ST_SCALE: state_nxt = ST_OUT;
            ST_OUT:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_lod   = (state == ST_LOD);
        ld_lut   = (state == ST_LUT);
        ld_scale = (state == ST_SCALE);
        ld_out   = (state == ST_OUT);
    end

    // ---- stage p1: leading-one detect, registered inside log2_q8 ----
    log2_q8 #(
        .AVG_W (AVG_W),
        .E_W   (E_W)
    ) u_log2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (ld_lod),
        .avg    (avg_lat),
        .log2_q (log2_q_p1)
    );

    // ---- stage p2: table lookup result captured ----
    // ---- stage p3: dB scaling ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log2_q_p2 <= '0;
            db_p3     <= '0;
        end else begin
            if (ld_lut)   log2_q_p2 <= log2_q_p1;
            if (ld_scale) db_p3     <= scale_db(log2_q_p2);
        end
    end

    // ---- output stage: results hold between pulses ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rssi_vld <= 1'b0;
            rssi_db  <= '0;
            avg_pow  <= '0;
        end else begin
            rssi_vld <= ld_out;
            if (ld_out) begin
                rssi_db <= db_p3;
                avg_pow <= avg_lat;
            end
        end
    end

endmodule

// File: tb/tb_rssi_pow_avg_db.sv
// Self-checking bench for rssi_pow_avg_db: a monitor models the window averaging,
// pushes expected mean / dB / pulse cycle when a window closes, and pops them when
// the DUT pulses rssi_vld.
module tb_rssi_pow_avg_db;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               pow_vld;
    logic signed [36:0] pow;
    logic               rssi_vld;
    logic [11:0]        rssi_db;
    logic [35:0]        avg_pow;

    typedef struct {
        longint avg;
        longint db;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    int     checks   = 0;
    int     failures = 0;
    int     pulses   = 0;
    int     cyc      = 0;
    longint last_db  = 0;
    longint last_avg = 0;
    longint acc_m    = 0;
    int     cnt_m    = 0;
    int     lut[16]  = '{0, 22, 44, 63, 82, 100, 118, 134, 150, 165, 179, 193, 207, 220, 232, 244};

    rssi_pow_avg_db #(
        .POW_WIDTH (37),
        .LOG2_WIN  (6),
        .DB_WIDTH  (12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .pow_vld  (pow_vld),
        .pow      (pow),
        .rssi_vld (rssi_vld),
        .rssi_db  (rssi_db),
        .avg_pow  (avg_pow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: 10*log10(avg) in Q8.4 via leading one + 16-entry log2 table.
    function automatic longint db_model(input longint avg);
        int     e;
        longint m;
        longint lq;
        e = 0;
        for (int i = 0; i < 36; i++) if (avg[i]) e = i;
        m  = ((avg << 4) >> e) & 15;
        lq = e * 256 + lut[m];
        return (lq * 771) >> 12;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    initial begin
        exp_t   x;
        longint s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_m = 0;
                cnt_m = 0;
                sb.delete();
            end else begin
                if (rssi_vld) begin
                    pulses++;
                    last_db  = rssi_db;
                    last_avg = avg_pow;
                    if (sb.size() == 0) begin
                        chk_val("spurious_pulse", rssi_vld, 0);
                    end else begin
                        x = sb.pop_front();
                        chk_val("avg_pow", avg_pow, x.avg);
                        chk_val("rssi_db", rssi_db, x.db);
                        chk_val("latency_cycle", cyc, x.cyc);
                    end
                end
                if (!en) begin
                    acc_m = 0;
                    cnt_m = 0;
                end else if (pow_vld) begin
                    s = (pow < 0) ? 0 : longint'(pow);
                    if (cnt_m == 63) begin
                        x.avg = (acc_m + s) >> 6;
                        x.db  = db_model(x.avg);
                        x.cyc = cyc + 5;
                        sb.push_back(x);
                        acc_m = 0;
                        cnt_m = 0;
                    end else begin
                        acc_m += s;
                        cnt_m++;
                    end
                end
            end
        end
    end

    task automatic drv(input logic e, input logic v, input longint p);
        @(posedge clk);
        #1;
        en      = e;
        pow_vld = v;
        pow     = p[36:0];
    endtask

    task automatic burst(input int n, input longint p);
        for (int i = 0; i < n; i++) drv(1'b1, 1'b1, p);
    endtask

    task automatic drain(input string tag, input int npulse, input int p0);
        for (int i = 0; i < 12; i++) drv(1'b1, 1'b0, 0);
        chk_val({tag, "_pending"}, sb.size(), 0);
        chk_val({tag, "_pulses"}, pulses - p0, npulse);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n   = 1'b0;
        en      = 1'b0;
        pow_vld = 1'b0;
        pow     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("reset_vld", rssi_vld, 0);
        chk_val("reset_db", rssi_db, 0);
        chk_val("reset_avg", avg_pow, 0);
        rst_n = 1'b1;
        drv(1'b1, 1'b0, 0);

        // constant 1024
        p0 = pulses;
        burst(64, 1024);
        drain("const1024", 1, p0);
        chk_val("const1024_db", last_db, 481);
        chk_val("const1024_avg", last_avg, 1024);

        // alternating 0 / 2048
        p0 = pulses;
        for (int i = 0; i < 64; i++) drv(1'b1, 1'b1, (i % 2) ? 2048 : 0);
        drain("alt", 1, p0);
        chk_val("alt_db", last_db, 481);
        chk_val("alt_avg", last_avg, 1024);

        // full scale
        p0 = pulses;
        burst(64, 64'h0000_000F_FFFF_FFFF);
        drain("max", 1, p0);
        chk_val("max_db", last_db, 1732);
        chk_val("max_avg", last_avg, 64'h0000_000F_FFFF_FFFF);

        // zeros then negatives
        p0 = pulses;
        burst(64, 0);
        burst(64, -5);
        drain("zero_neg", 2, p0);
        chk_val("zero_neg_db", last_db, 0);
        chk_val("zero_neg_avg", last_avg, 0);

        // en drop mid-window
        p0 = pulses;
        burst(30, 7);
        drv(1'b0, 1'b0, 0);
        burst(64, 16);
        drain("en_drop", 1, p0);
        chk_val("en_drop_db", last_db, 192);

        // en low on what would be the closing sample
        p0 = pulses;
        burst(63, 100);
        drv(1'b0, 1'b1, 100);
        burst(64, 16);
        drain("en_last", 1, p0);
        chk_val("en_last_db", last_db, 192);

        // back-to-back windows, random samples every cycle
        p0 = pulses;
        for (int i = 0; i < 192; i++) drv(1'b1, 1'b1, longint'($urandom_range(0, 200000)));
        drain("b2b", 3, p0);

        // reset during a conversion: aborted, no pulse, outputs cleared
        p0 = pulses;
        burst(64, 1024);
        drv(1'b1, 1'b0, 0);
        drv(1'b1, 1'b0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain("midreset", 0, p0);
        chk_val("midreset_db", rssi_db, 0);
        chk_val("midreset_avg", avg_pow, 0);

        // recovery after reset
        p0 = pulses;
        burst(64, 16);
        drain("recover", 1, p0);
        chk_val("recover_db", last_db, 192);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
